// File: rtl/alu_pkg.sv
// Shared constants and enums for the ALU issue controller and its register file.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int ADDR_W  = 3;

  typedef enum logic [2:0] {
    OP_INCNOT = 3'd0,
    OP_INC    = 3'd1,
    OP_ADDC   = 3'd2,
    OP_ADDSHR = 3'd3,
    OP_AND    = 3'd4,
    OP_OR     = 3'd5,
    OP_PACK   = 3'd6,
    OP_NOP    = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational operand read ports, one debug read port,
// and a single synchronous write port. All entries clear on reset.
module alu_regfile #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 16-bit ALU: accepts one command at a time,
// drives the ALU from latched operands and writes results and flags back.
module alu_issue_ctrl #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_sa,
  input  logic [ADDR_W-1:0] cmd_sb,
  input  logic              cmd_cin,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_c,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_w,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              done,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_pkg::*;

  issue_state_e      state, state_next;
  logic [ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              accept, exec_write;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign accept     = cmd_valid && (state == IDLE);
  assign exec_write = (state == EXEC) && (alu_op != OP_NOP);

  // Loads write at the accept edge; ALU results write at the end of EXEC.
  assign we    = (accept && cmd_load) || exec_write;
  assign waddr = (state == IDLE) ? cmd_dst : dst_q;
  assign wdata = (state == IDLE) ? cmd_imm : alu_w;

  alu_regfile #(
    .DATA_W (DATA_W),
    .REG_CNT(REG_CNT),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_sa),
    .rdata_a (rd_a),
    .raddr_b (cmd_sb),
    .rdata_b (rd_b),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = cmd_load ? DONE : EXEC;
        end
      end
      EXEC: state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latches only change on an accepted ALU command, so register-file
  // writes never disturb what the ALU sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_c  <= 1'b0;
      alu_op <= 3'd0;
      dst_q  <= '0;
    end else if (accept && !cmd_load) begin
      alu_a  <= rd_a;
      alu_b  <= rd_b;
      alu_c  <= cmd_cin;
      alu_op <= cmd_op;
      dst_q  <= cmd_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (exec_write) begin
      flag_z <= alu_zero;
      flag_n <= alu_neg;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, randomized
// commands against a register-array model, handshake pressure and mid-op reset.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_sa, cmd_sb;
  logic        cmd_cin;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a, alu_b, alu_w;
  logic        alu_c;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_neg;
  logic        done, flag_z, flag_n;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_cmp;
  int n_fail;
  int done_count;

  logic [15:0] model [8];
  logic        model_z, model_n;

  typedef struct {
    logic        load;
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic        cin;
    logic [15:0] imm;
    logic [15:0] exp_val;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vecs [11];

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_load (cmd_load),
    .cmd_op   (cmd_op),
    .cmd_dst  (cmd_dst),
    .cmd_sa   (cmd_sa),
    .cmd_sb   (cmd_sb),
    .cmd_cin  (cmd_cin),
    .cmd_imm  (cmd_imm),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_op   (alu_op),
    .alu_w    (alu_w),
    .alu_zero (alu_zero),
    .alu_neg  (alu_neg),
    .done     (done),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: any fixed function of the operands works for this block.
  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic c, input logic [2:0] op);
    logic [16:0] s;
    case (op)
      3'd0: return (a & ~b) + 16'd1;
      3'd1: return a + 16'd1;
      3'd2: return a + b + {15'd0, c};
      3'd3: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, c};
        return s[16:1];
      end
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return {a[7:0], b[7:0]};
      default: return a;
    endcase
  endfunction

  assign alu_w    = alu_model(alu_a, alu_b, alu_c, alu_op);
  assign alu_zero = (alu_w == 16'd0);
  assign alu_neg  = alu_w[15];

  always @(negedge clk) begin
    if (rst_n && done) done_count++;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic read_dbg(input logic [2:0] addr, output logic [15:0] data);
    dbg_addr = addr;
    #1;
    data = dbg_data;
  endtask

  task automatic check_all_regs(input string name);
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      read_dbg(3'(i), d);
      checkOutput($sformatf("%s_r%0d", name, i), 32'(d), 32'(model[i]));
    end
  endtask

  task automatic model_apply(input vec_t v);
    logic [15:0] w;
    if (v.load) begin
      model[v.dst] = v.imm;
    end else if (v.op != 3'd7) begin
      w = alu_model(model[v.sa], model[v.sb], v.cin, v.op);
      model[v.dst] = w;
      model_z = (w == 16'd0);
      model_n = w[15];
    end
  endtask

  // Issues one command, checks handshake, operands, done timing, result and flags.
  task automatic applyStimulus(input vec_t v);
    logic [15:0] ea, eb, d;
    int          k;
    bit          got;
    ea = model[v.sa];
    eb = model[v.sb];
    @(negedge clk);
    cmd_load  = v.load;
    cmd_op    = v.op;
    cmd_dst   = v.dst;
    cmd_sa    = v.sa;
    cmd_sb    = v.sb;
    cmd_cin   = v.cin;
    cmd_imm   = v.imm;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      checkOutput("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    got = 1'b0;
    for (k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1 && !v.load) begin
        checkOutput("exec_ready", 32'(cmd_ready), 32'd0);
        checkOutput("alu_a", 32'(alu_a), 32'(ea));
        checkOutput("alu_b", 32'(alu_b), 32'(eb));
        checkOutput("alu_c", 32'(alu_c), 32'(v.cin));
        checkOutput("alu_op", 32'(alu_op), 32'(v.op));
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("done_latency", got ? 32'(k) : 32'd99, v.load ? 32'd1 : 32'd2);
    @(negedge clk);
    checkOutput("done_width", 32'(done), 32'd0);
    checkOutput("ready_after", 32'(cmd_ready), 32'd1);
    model_apply(v);
    read_dbg(v.dst, d);
    checkOutput("dst_val", 32'(d), 32'(model[v.dst]));
    checkOutput("flag_z", 32'(flag_z), 32'(model_z));
    checkOutput("flag_n", 32'(flag_n), 32'(model_n));
  endtask

  initial begin
    vec_t        v;
    logic [15:0] d;
    int          accepts, last, d0;

    n_cmp = 0;
    n_fail = 0;
    done_count = 0;
    for (int i = 0; i < 8; i++) model[i] = 16'd0;
    model_z = 1'b0;
    model_n = 1'b0;

    vecs[0]  = '{1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0005, 16'h0005, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 3'd2, 3'd0, 3'd0, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 16'h0000, 16'h0009, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 3'd4, 3'd4, 3'd4, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'd1, 3'd5, 3'd5, 3'd5, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 1'b0, 16'h00F0, 16'h00F0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16'h0F00, 16'h0F00, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 3'd4, 3'd6, 3'd6, 3'd7, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd7, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_load = 1'b0;
    cmd_op = 3'd0;
    cmd_dst = 3'd0;
    cmd_sa = 3'd0;
    cmd_sb = 3'd0;
    cmd_cin = 1'b0;
    cmd_imm = 16'd0;
    dbg_addr = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_flags", 32'({flag_z, flag_n}), 32'd0);
    checkOutput("rst_alu", 32'({alu_c, alu_op}), 32'd0);
    checkOutput("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    check_all_regs("rst");

    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      read_dbg(vecs[i].dst, d);
      checkOutput($sformatf("tbl%0d_val", i), 32'(d), 32'(vecs[i].exp_val));
      checkOutput($sformatf("tbl%0d_z", i), 32'(flag_z), 32'(vecs[i].exp_z));
      checkOutput($sformatf("tbl%0d_n", i), 32'(flag_n), 32'(vecs[i].exp_n));
    end
    read_dbg(3'd1, d);
    checkOutput("tbl_r1_kept", 32'(d), 32'h0005);

    $display("[TB] randomized commands");
    for (int i = 0; i < 60; i++) begin
      v.load = ($urandom_range(0, 3) == 0);
      v.op   = 3'($urandom_range(0, 7));
      v.dst  = 3'($urandom_range(0, 7));
      v.sa   = 3'($urandom_range(0, 7));
      v.sb   = 3'($urandom_range(0, 7));
      v.cin  = 1'($urandom_range(0, 1));
      v.imm  = 16'($urandom);
      v.exp_val = 16'd0;
      v.exp_z = 1'b0;
      v.exp_n = 1'b0;
      applyStimulus(v);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_all_regs("rand");

    $display("[TB] back-to-back with cmd_valid held high");
    @(negedge clk);
    cmd_load = 1'b0;
    cmd_op = 3'd2;
    cmd_dst = 3'd3;
    cmd_sa = 3'd1;
    cmd_sb = 3'd2;
    cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    accepts = 0;
    last = -1;
    d0 = done_count;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cmd_ready) begin
        if (last >= 0) checkOutput("accept_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        accepts++;
        if (accepts == 4) break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("press_accepts", 32'(accepts), 32'd4);
    checkOutput("press_dones", 32'(done_count - d0), 32'd4);
    v = '{1'b0, 3'd2, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    model_apply(v);
    check_all_regs("press");
    checkOutput("press_z", 32'(flag_z), 32'(model_z));
    checkOutput("press_n", 32'(flag_n), 32'(model_n));

    $display("[TB] reset during EXEC");
    @(negedge clk);
    cmd_load = 1'b0;
    cmd_op = 3'd5;
    cmd_dst = 3'd4;
    cmd_sa = 3'd1;
    cmd_sb = 3'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_exec_ready", 32'(cmd_ready), 32'd0);
    d0 = done_count;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 8; i++) model[i] = 16'd0;
    model_z = 1'b0;
    model_n = 1'b0;
    checkOutput("mid_rst_dones", 32'(done_count - d0), 32'd0);
    checkOutput("mid_rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mid_rst_flags", 32'({flag_z, flag_n}), 32'd0);
    checkOutput("mid_rst_alu", 32'({alu_c, alu_op}), 32'd0);
    checkOutput("mid_rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    check_all_regs("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
